// File: rtl/native_crossbar_nports_if.sv
// Bundle of native-port and bank-side signals for the N-port crossbar.
// The slave modport is the crossbar's view. The master modport is the user/controller view.
interface native_crossbar_nports_if #(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 8,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 128
);
    localparam int BB  = $clog2(NUM_BANKS);
    localparam int BAW = ADDR_WIDTH - BB;
    localparam int BEW = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]            cmd_valid;
    logic [NUM_PORTS-1:0]            cmd_ready;
    logic [NUM_PORTS-1:0]            cmd_we;
    logic [NUM_PORTS-1:0]            cmd_mw;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] cmd_addr;

    logic [NUM_PORTS-1:0]            wdata_valid;
    logic [NUM_PORTS-1:0]            wdata_ready;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_data;
    logic [NUM_PORTS*BEW-1:0]        wdata_we;

    logic [NUM_PORTS-1:0]            rdata_valid;
    logic [NUM_PORTS-1:0]            rdata_ready;
    logic [DATA_WIDTH-1:0]           rdata_data;

    logic [NUM_BANKS-1:0]            bank_valid;
    logic [NUM_BANKS-1:0]            bank_ready;
    logic [NUM_BANKS-1:0]            bank_we;
    logic [NUM_BANKS-1:0]            bank_mw;
    logic [NUM_BANKS-1:0]            bank_lock;
    logic [NUM_BANKS*BAW-1:0]        bank_addr;
    logic [NUM_BANKS-1:0]            bank_wdata_ready;
    logic [NUM_BANKS-1:0]            bank_rdata_valid;

    logic [DATA_WIDTH-1:0]           interface_wdata;
    logic [BEW-1:0]                  interface_wdata_we;
    logic [DATA_WIDTH-1:0]           interface_rdata;

    modport master (
        output cmd_valid, cmd_we, cmd_mw, cmd_addr,
        output wdata_valid, wdata_data, wdata_we,
        output rdata_ready,
        output bank_ready, bank_wdata_ready, bank_rdata_valid,
        output interface_rdata,
        input  cmd_ready, wdata_ready, rdata_valid, rdata_data,
        input  bank_valid, bank_we, bank_mw, bank_lock, bank_addr,
        input  interface_wdata, interface_wdata_we
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_mw, cmd_addr,
        input  wdata_valid, wdata_data, wdata_we,
        input  rdata_ready,
        input  bank_ready, bank_wdata_ready, bank_rdata_valid,
        input  interface_rdata,
        output cmd_ready, wdata_ready, rdata_valid, rdata_data,
        output bank_valid, bank_we, bank_mw, bank_lock, bank_addr,
        output interface_wdata, interface_wdata_we
    );
endinterface

// File: rtl/native_crossbar_nports.sv
// N-port native-to-bank crossbar: per-bank lock-aware round-robin arbitration,
// latency-delayed write-ready/read-valid return strobes and sticky return-path fault flags.
module native_crossbar_nports #(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 8,
    parameter int ADDR_WIDTH = 26,
    parameter int BANK_SHIFT = 10,
    parameter int DATA_WIDTH = 128,
    parameter int LAT_MAX    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           crb_READ_LATENCY_cfg,
    input  logic [7:0]           crb_WRITE_LATENCY_cfg,
    native_crossbar_nports_if.slave bus,
    output logic [NUM_PORTS-1:0] rdata_drop,
    output logic                 wdata_conflict
);
    localparam int BB  = $clog2(NUM_BANKS);
    localparam int BAW = ADDR_WIDTH - BB;
    localparam int HIW = ADDR_WIDTH - BANK_SHIFT - BB;
    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BEW = DATA_WIDTH / 8;

    // Tap k of a delay line holds the strobe from k cycles ago; lat 0 is the live strobe.
    function automatic logic tap(input logic [LAT_MAX-1:0] line, input logic [7:0] lat,
                                 input logic now);
        logic t;
        t = now;
        for (int k = 1; k <= LAT_MAX; k++) begin
            if (lat == 8'(k)) begin
                t = line[k-1];
            end
        end
        return t;
    endfunction

    logic [BB-1:0]                       port_bank  [NUM_PORTS];
    logic [BAW-1:0]                      port_baddr [NUM_PORTS];
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] accept_m;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] wstb_m;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] rstb_m;
    logic [NUM_PORTS-1:0]                wready;
    logic [NUM_PORTS-1:0]                rvalid;
    logic [7:0]                          wr_lat;
    logic [7:0]                          rd_lat;
    logic [DATA_WIDTH-1:0]               wdata_mux;
    logic [BEW-1:0]                      wdata_we_mux;
    logic                                conflict_reg;
    logic [NUM_PORTS-1:0]                drop_reg;
    logic                                unused_wdata_valid;

    assign wr_lat = (crb_WRITE_LATENCY_cfg > 8'(LAT_MAX)) ? 8'(LAT_MAX) : crb_WRITE_LATENCY_cfg;
    assign rd_lat = (crb_READ_LATENCY_cfg  > 8'(LAT_MAX)) ? 8'(LAT_MAX) : crb_READ_LATENCY_cfg;

    // Write data is accepted by the controller on the returned ready strobe alone.
    assign unused_wdata_valid = ^bus.wdata_valid;

    genvar gi, gj;

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_decode
            assign port_bank[gi]  = bus.cmd_addr[gi*ADDR_WIDTH + BANK_SHIFT +: BB];
            assign port_baddr[gi] = {bus.cmd_addr[gi*ADDR_WIDTH + BANK_SHIFT + BB +: HIW],
                                     bus.cmd_addr[gi*ADDR_WIDTH +: BANK_SHIFT]};
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [NUM_PORTS-1:0] req;
            logic [NUM_PORTS-1:0] sel;
            logic [PW-1:0]        grant_reg;
            logic [PW-1:0]        grant_next;
            logic [PW-1:0]        cand;
            logic                 owner_reg;
            logic                 found;
            logic                 own_req;
            logic                 lock;

            for (gj = 0; gj < NUM_PORTS; gj++) begin : g_req
                assign req[gj] = bus.cmd_valid[gj] & (port_bank[gj] == BB'(gi));
                assign sel[gj] = (grant_reg == PW'(gj));
            end

            assign own_req = owner_reg & req[grant_reg];
            assign lock    = own_req & ~bus.bank_ready[gi];

            assign bus.bank_valid[gi]            = own_req;
            assign bus.bank_lock[gi]             = lock;
            assign bus.bank_we[gi]               = bus.cmd_we[grant_reg];
            assign bus.bank_mw[gi]               = bus.cmd_mw[grant_reg];
            assign bus.bank_addr[gi*BAW +: BAW]  = port_baddr[grant_reg];

            assign accept_m[gi] = sel & {NUM_PORTS{own_req & bus.bank_ready[gi]}};
            assign wstb_m[gi]   = sel & {NUM_PORTS{bus.bank_wdata_ready[gi]}};
            assign rstb_m[gi]   = sel & {NUM_PORTS{bus.bank_rdata_valid[gi]}};

            // Circular search starting after the current grant; the current grant is checked last.
            always_comb begin
                found      = 1'b0;
                grant_next = grant_reg;
                cand       = grant_reg;
                for (int i = 1; i <= NUM_PORTS; i++) begin
                    cand = PW'((int'(grant_reg) + i) % NUM_PORTS);
                    if (!found && req[cand]) begin
                        found      = 1'b1;
                        grant_next = cand;
                    end
                end
            end

            // Without a lock the owner is either idle or has just handshaked, so re-arbitrate.
            always_ff @(posedge clk) begin
                if (rst) begin
                    grant_reg <= '0;
                    owner_reg <= 1'b0;
                end else if (!lock) begin
                    grant_reg <= grant_next;
                    owner_reg <= found;
                end
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic                 acc;
            logic                 ws;
            logic                 rs;
            logic [LAT_MAX-1:0]   wline_reg;
            logic [LAT_MAX-1:0]   rline_reg;

            always_comb begin
                acc = 1'b0;
                ws  = 1'b0;
                rs  = 1'b0;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    acc = acc | accept_m[b][gi];
                    ws  = ws  | wstb_m[b][gi];
                    rs  = rs  | rstb_m[b][gi];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wline_reg <= '0;
                    rline_reg <= '0;
                end else begin
                    wline_reg <= (wline_reg << 1) | LAT_MAX'(ws);
                    rline_reg <= (rline_reg << 1) | LAT_MAX'(rs);
                end
            end

            assign bus.cmd_ready[gi] = acc;
            assign wready[gi]        = tap(wline_reg, wr_lat, ws);
            assign rvalid[gi]        = tap(rline_reg, rd_lat, rs);
        end
    endgenerate

    // Lowest-index ready port wins the shared write data bus.
    always_comb begin
        wdata_mux    = '0;
        wdata_we_mux = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (wready[p]) begin
                wdata_mux    = bus.wdata_data[p*DATA_WIDTH +: DATA_WIDTH];
                wdata_we_mux = bus.wdata_we[p*BEW +: BEW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_reg <= 1'b0;
            drop_reg     <= '0;
        end else begin
            if ((wready & (wready - NUM_PORTS'(1))) != '0) begin
                conflict_reg <= 1'b1;
            end
            drop_reg <= drop_reg | (rvalid & ~bus.rdata_ready);
        end
    end

    assign bus.wdata_ready        = wready;
    assign bus.rdata_valid        = rvalid;
    assign bus.rdata_data         = bus.interface_rdata;
    assign bus.interface_wdata    = wdata_mux;
    assign bus.interface_wdata_we = wdata_we_mux;
    assign rdata_drop             = drop_reg;
    assign wdata_conflict         = conflict_reg;
endmodule
